// File: rtl/video_compositor.sv
// Final RGB888 pixel builder: selects a background mode, then composites prioritised overlay layers.
// Two-stage pipeline; config is shadowed at frame start so changes never tear mid-frame.
module video_compositor #(
  parameter int NUM_OVERLAYS = 4,
  parameter int SIDEBAND_W   = 22,
  parameter int BLINK_PERIOD = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      pixel_valid_in,
  input  logic                      frame_start_in,
  input  logic [SIDEBAND_W-1:0]     sideband_in,
  input  logic [23:0]               camera_pixel_in,
  input  logic [7:0]                sel_channel_in,
  input  logic                      thresholded_pixel_in,
  input  logic [NUM_OVERLAYS-1:0]   overlay_in,
  input  logic [1:0]                bg_mode_in,
  input  logic [23:0]               thresh_color_in,
  input  logic [NUM_OVERLAYS-1:0]   overlay_en_in,
  input  logic [NUM_OVERLAYS-1:0]   overlay_blink_in,
  input  logic [NUM_OVERLAYS-1:0]   overlay_blend_in,
  input  logic [24*NUM_OVERLAYS-1:0] overlay_color_in,
  output logic [23:0]               pixel_out,
  output logic                      pixel_valid_out,
  output logic [SIDEBAND_W-1:0]     sideband_out
);

  localparam int N     = NUM_OVERLAYS;
  localparam int CNT_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

  // Handshake: valid-only stream, no ready. pixel_valid_in marks a pixel this cycle;
  // pixel_valid_out qualifies pixel_out exactly 2 cycles later. Data moves every cycle regardless.

  logic [1:0]     sh_mode;
  logic [23:0]    sh_thresh_color;
  logic [N-1:0]   sh_en, sh_blink, sh_blend;
  logic [24*N-1:0] sh_color;
  logic [CNT_W-1:0] blink_cnt;
  logic           on_phase;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sh_mode         <= '0;
      sh_thresh_color <= '0;
      sh_en           <= '0;
      sh_blink        <= '0;
      sh_blend        <= '0;
      sh_color        <= '0;
      blink_cnt       <= '0;
    end else if (frame_start_in) begin
      sh_mode         <= bg_mode_in;
      sh_thresh_color <= thresh_color_in;
      sh_en           <= overlay_en_in;
      sh_blink        <= overlay_blink_in;
      sh_blend        <= overlay_blend_in;
      sh_color        <= overlay_color_in;
      blink_cnt       <= (blink_cnt == CNT_W'(BLINK_PERIOD - 1)) ? '0 : blink_cnt + CNT_W'(1);
    end
  end

  assign on_phase = (blink_cnt < CNT_W'(BLINK_PERIOD / 2));

  logic [23:0]  bg_d, gray;
  logic [N-1:0] active_d;

  always_comb begin
    gray = {sel_channel_in, sel_channel_in, sel_channel_in};
    bg_d = gray;
    case (sh_mode)
      2'd0: bg_d = camera_pixel_in;
      2'd1: bg_d = thresholded_pixel_in ? sh_thresh_color : gray;
      2'd2: bg_d = thresholded_pixel_in ? sh_thresh_color : 24'h000000;
      default: bg_d = gray;
    endcase
    active_d = overlay_in & sh_en & (~sh_blink | {N{on_phase}});
  end

  // Stage 1 carries the colours and blend bits it was resolved with, so a frame_start
  // landing while this pixel is in flight cannot change how it is finished.
  logic                  s1_valid;
  logic [SIDEBAND_W-1:0] s1_sb;
  logic [23:0]           s1_bg;
  logic [N-1:0]          s1_active, s1_blend;
  logic [24*N-1:0]       s1_color;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid  <= 1'b0;
      s1_sb     <= '0;
      s1_bg     <= '0;
      s1_active <= '0;
      s1_blend  <= '0;
      s1_color  <= '0;
    end else begin
      s1_valid  <= pixel_valid_in;
      s1_sb     <= sideband_in;
      s1_bg     <= bg_d;
      s1_active <= active_d;
      s1_blend  <= sh_blend;
      s1_color  <= sh_color;
    end
  end

  function automatic logic [23:0] blend_half(input logic [23:0] a, input logic [23:0] b);
    blend_half[23:16] = {1'b0, a[23:17]} + {1'b0, b[23:17]};
    blend_half[15:8]  = {1'b0, a[15:9]}  + {1'b0, b[15:9]};
    blend_half[7:0]   = {1'b0, a[7:1]}   + {1'b0, b[7:1]};
  endfunction

  logic [23:0] comp_d;

  // Walk from the lowest priority upward so the lowest active index is written last.
  always_comb begin
    comp_d = s1_bg;
    for (int i = N - 1; i >= 0; i--) begin
      if (s1_active[i])
        comp_d = s1_blend[i] ? blend_half(s1_bg, s1_color[24*i +: 24]) : s1_color[24*i +: 24];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      sideband_out    <= '0;
    end else begin
      pixel_out       <= comp_d;
      pixel_valid_out <= s1_valid;
      sideband_out    <= s1_sb;
    end
  end

endmodule

// File: tb/tb_video_compositor.sv
// Directed bench for video_compositor: latency, background modes, priority, blend,
// shadowed config, blink phase and mid-frame reset.
module tb_video_compositor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv, fs, thr;
  logic [21:0] sb;
  logic [23:0] cam, tcol;
  logic [7:0]  sel;
  logic [3:0]  ovl, en, blk, bld;
  logic [1:0]  mode;
  logic [95:0] ocol;
  logic [23:0] pix;
  logic        pvo;
  logic [21:0] sbo;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];

  video_compositor #(.NUM_OVERLAYS(4), .SIDEBAND_W(22), .BLINK_PERIOD(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .pixel_valid_in(pv), .frame_start_in(fs),
    .sideband_in(sb), .camera_pixel_in(cam), .sel_channel_in(sel),
    .thresholded_pixel_in(thr), .overlay_in(ovl), .bg_mode_in(mode),
    .thresh_color_in(tcol), .overlay_en_in(en), .overlay_blink_in(blk),
    .overlay_blend_in(bld), .overlay_color_in(ocol),
    .pixel_out(pix), .pixel_valid_out(pvo), .sideband_out(sbo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic frame_start();
    fs = 1'b1;
    step();
    fs = 1'b0;
  endtask

  // Drive one valid pixel (optionally on a frame_start cycle) and compare it 2 cycles later.
  task automatic send_px(input string tag, input logic pulse, input logic [23:0] c,
                         input logic [7:0] s, input logic t, input logic [3:0] o,
                         input logic [23:0] exp);
    cam = c; sel = s; thr = t; ovl = o; pv = 1'b1; fs = pulse;
    exp_q.push_back(exp);
    step();
    pv = 1'b0; fs = 1'b0;
    step();
    check(tag, pix, exp_q.pop_front());
    check({tag, "_valid"}, pvo, 1);
  endtask

  initial begin
    rst_n = 1'b0; pv = 0; fs = 0; thr = 0; sb = '0; cam = '0; tcol = '0; sel = '0;
    ovl = '0; en = '0; blk = '0; bld = '0; mode = 2'd0; ocol = '0;
    repeat (3) step();
    check("rst_pixel", pix, 0);
    check("rst_valid", pvo, 0);
    check("rst_sideband", sbo, 0);
    rst_n = 1'b1;
    step();

    // Latency: output appears at t+2 only.
    cam = 24'h123456; sb = 22'h2AAAA; pv = 1'b1;
    step();
    pv = 1'b0; sb = '0;
    check("lat_t1_valid", pvo, 0);
    step();
    check("lat_pixel", pix, 24'h123456);
    check("lat_valid", pvo, 1);
    check("lat_sideband", sbo, 22'h2AAAA);
    step();
    check("lat_t3_valid", pvo, 0);

    // Background modes.
    tcol = 24'hFF77AA;
    mode = 2'd1; frame_start();
    send_px("m1_t0", 0, 24'h0, 8'h40, 0, 4'b0000, 24'h404040);
    send_px("m1_t1", 0, 24'h0, 8'h40, 1, 4'b0000, 24'hFF77AA);
    mode = 2'd2; frame_start();
    send_px("m2_t0", 0, 24'h0, 8'h40, 0, 4'b0000, 24'h000000);
    send_px("m2_t1", 0, 24'h0, 8'h40, 1, 4'b0000, 24'hFF77AA);
    mode = 2'd3; frame_start();
    send_px("m3_t0", 0, 24'h0, 8'h40, 0, 4'b0000, 24'h404040);
    send_px("m3_t1", 0, 24'h0, 8'h40, 1, 4'b0000, 24'h404040);

    // Priority.
    mode = 2'd0; en = 4'b0110;
    ocol[24*1 +: 24] = 24'h00FF00;
    ocol[24*2 +: 24] = 24'h0000FF;
    frame_start();
    send_px("prio_1110", 0, 24'h111111, 8'h0, 0, 4'b1110, 24'h00FF00);
    send_px("prio_1100", 0, 24'h111111, 8'h0, 0, 4'b1100, 24'h0000FF);
    send_px("prio_dis0", 0, 24'h111111, 8'h0, 0, 4'b0001, 24'h111111);

    // Blend.
    en = 4'b0001; bld = 4'b0001; ocol[23:0] = 24'hFF0000; frame_start();
    send_px("blend", 0, 24'h00FF81, 8'h0, 0, 4'b0001, 24'h7F7F40);

    // Shadow / tearing.
    bld = 4'b0000; frame_start();
    mode = 2'd3; en = 4'b0000; ocol[23:0] = 24'h00FF00;
    send_px("tear_mid_bg", 0, 24'hAABBCC, 8'h40, 0, 4'b0000, 24'hAABBCC);
    send_px("tear_mid_ovl", 0, 24'hAABBCC, 8'h40, 0, 4'b0001, 24'hFF0000);
    send_px("tear_pulse_ovl", 1, 24'hAABBCC, 8'h40, 0, 4'b0001, 24'hFF0000);
    send_px("tear_new_bg", 0, 24'hAABBCC, 8'h40, 0, 4'b0000, 24'h404040);
    send_px("tear_new_ovl", 0, 24'hAABBCC, 8'h40, 0, 4'b0001, 24'h404040);
    mode = 2'd0;
    send_px("tear_pulse_mode", 1, 24'hAABBCC, 8'h40, 0, 4'b0000, 24'h404040);
    send_px("tear_mode0", 0, 24'hAABBCC, 8'h40, 0, 4'b0000, 24'hAABBCC);

    // Mid-frame reset: outputs drop at once.
    cam = 24'h555555; sb = 22'h15555; ovl = 4'b0000; pv = 1'b1;
    step();
    step();
    check("mrst_pre_valid", pvo, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", pvo, 0);
    check("mrst_pixel", pix, 0);
    check("mrst_sideband", sbo, 0);
    pv = 1'b0; sb = '0;
    step();
    rst_n = 1'b1;
    step();
    check("mrst_after_valid", pvo, 0);

    // Blink: counter after k pulses is k mod 4; on-phase when counter < 2.
    mode = 2'd0; en = 4'b0001; blk = 4'b0001; bld = 4'b0000; ocol[23:0] = 24'hFF0000;
    for (int f = 1; f <= 6; f++) begin
      frame_start();
      send_px($sformatf("blink_f%0d", f), 0, 24'h000055, 8'h0, 0, 4'b0001,
              ((f % 4) < 2) ? 24'hFF0000 : 24'h000055);
    end

    // Counter sits at 2 (off); reset must restart it at 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    frame_start();
    send_px("blink_rst_c1", 0, 24'h000055, 8'h0, 0, 4'b0001, 24'hFF0000);
    frame_start();
    send_px("blink_rst_c2", 0, 24'h000055, 8'h0, 0, 4'b0001, 24'h000055);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
